hilo_muldiv_unit: RTL

HILO_MULDIV_UNIT -- requirements
Module: hilo_muldiv_unit

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_absneg.sv | 11 +
 rtl/hilo_muldiv_unit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared operation encodings, FSM state type and default operand width for
// the Hi/Lo multiply/divide unit.
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_absneg.sv
// Combinational conditional two's-complement negate; used both to take operand
// magnitudes and to restore the sign of finished results.
module muldiv_absneg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] result_o
);
    assign result_o = neg_i ? (~value_i + WIDTH'(1)) : value_i;
endmodule

// File: rtl/hilo_muldiv_unit.sv
// Hi/Lo unit: one-bit-per-cycle MULT/MULTU, MTHI/MTLO, and restoring DIV/DIVU
// when the MULDIV_DIV_EN macro is defined (otherwise DIV/DIVU act as reserved).
module hilo_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);
    localparam int               CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [2:0]         op_q;
    logic               sign_a_q, sign_b_q;
    logic [WIDTH-1:0]   opnd_q, acc_hi_q, acc_lo_q, hi_q, lo_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               done_q, pend_q;

    logic               accept, launch, is_mul_in, is_signed_in, signed_op;
    logic [WIDTH-1:0]   mag_a, mag_b, step_hi, step_lo, res_hi, res_lo;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_fixed;

    assign accept       = start && (state_q == IDLE);
    assign is_mul_in    = (op == OP_MULT) || (op == OP_MULTU);
    assign is_signed_in = (op == OP_MULT) || (op == OP_DIV);
    assign signed_op    = (op_q == OP_MULT) || (op_q == OP_DIV);

    muldiv_absneg #(.WIDTH(WIDTH)) u_abs_a (
        .value_i (src_a),
        .neg_i   (is_signed_in && src_a[WIDTH-1]),
        .result_o(mag_a)
    );
    muldiv_absneg #(.WIDTH(WIDTH)) u_abs_b (
        .value_i (src_b),
        .neg_i   (is_signed_in && src_b[WIDTH-1]),
        .result_o(mag_b)
    );
    muldiv_absneg #(.WIDTH(2 * WIDTH)) u_fix_prod (
        .value_i ({acc_hi_q, acc_lo_q}),
        .neg_i   (signed_op && (sign_a_q ^ sign_b_q)),
        .result_o(prod_fixed)
    );

    // Shift-add: acc_lo holds the unconsumed multiplier bits, acc_hi the partial sum.
    assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);

`ifdef MULDIV_DIV_EN
    logic             is_div_run, div_zero_in, div_ge, pend_dbz_q, dbz_q;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff, quo_fixed, rem_fixed;

    assign div_zero_in = ((op == OP_DIV) || (op == OP_DIVU)) && (src_b == '0);
    assign launch      = accept && (is_mul_in || op == OP_DIV || op == OP_DIVU) && !div_zero_in;
    assign is_div_run  = (op_q == OP_DIV) || (op_q == OP_DIVU);

    // Restoring step: acc_hi is the partial remainder, acc_lo shifts dividend out, quotient in.
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;

    muldiv_absneg #(.WIDTH(WIDTH)) u_fix_quo (
        .value_i (acc_lo_q),
        .neg_i   (signed_op && (sign_a_q ^ sign_b_q)),
        .result_o(quo_fixed)
    );
    muldiv_absneg #(.WIDTH(WIDTH)) u_fix_rem (
        .value_i (acc_hi_q),
        .neg_i   (signed_op && sign_a_q),
        .result_o(rem_fixed)
    );

    assign step_hi = is_div_run ? (div_ge ? div_diff : div_shift[WIDTH-1:0]) : mul_sum[WIDTH:1];
    assign step_lo = is_div_run ? {acc_lo_q[WIDTH-2:0], div_ge} : {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    assign res_hi  = is_div_run ? rem_fixed : prod_fixed[2*WIDTH-1:WIDTH];
    assign res_lo  = is_div_run ? quo_fixed : prod_fixed[WIDTH-1:0];

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            pend_dbz_q <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            pend_dbz_q <= accept && div_zero_in;
            dbz_q      <= pend_q && pend_dbz_q;
        end
    end
    assign div_by_zero = dbz_q;
`else
    assign launch      = accept && is_mul_in;
    assign step_hi     = mul_sum[WIDTH:1];
    assign step_lo     = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    assign res_hi      = prod_fixed[2*WIDTH-1:WIDTH];
    assign res_lo      = prod_fixed[WIDTH-1:0];
    assign div_by_zero = 1'b0;
`endif

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (launch) state_d = RUN;
            RUN:     if (cnt_q == LAST_ITER) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            opnd_q   <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= pend_q;
            pend_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q     <= op;
                        sign_a_q <= src_a[WIDTH-1];
                        sign_b_q <= src_b[WIDTH-1];
                        cnt_q    <= '0;
                        if (launch) begin
                            opnd_q   <= is_mul_in ? mag_a : mag_b;
                            acc_hi_q <= '0;
                            acc_lo_q <= is_mul_in ? mag_b : mag_a;
                        end else begin
                            // Single-cycle ops: done follows one edge later, busy stays low.
                            pend_q <= 1'b1;
                            if (op == OP_MTHI) hi_q <= src_a;
                            if (op == OP_MTLO) lo_q <= src_a;
                        end
                    end
                end
                RUN: begin
                    cnt_q    <= cnt_q + CNT_W'(1);
                    acc_hi_q <= step_hi;
                    acc_lo_q <= step_lo;
                end
                FIX: begin
                    hi_q   <= res_hi;
                    lo_q   <= res_lo;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign Hi   = hi_q;
    assign Lo   = lo_q;

endmodule
